// File: rtl/ensemble_vote_collector_if.sv
// AXI-Stream style link used for the classifier result streams and the vote output.
interface ensemble_vote_collector_if #(
  parameter int DATA_WIDTH = 32,
  parameter int KEEP_WIDTH = 4
);
  logic [DATA_WIDTH-1:0] tdata;
  logic [KEEP_WIDTH-1:0] tkeep;
  logic                  tvalid;
  logic                  tready;
  logic                  tlast;

  modport master (output tdata, output tkeep, output tvalid, output tlast, input tready);
  modport slave  (input tdata, input tkeep, input tvalid, input tlast, output tready);
endinterface

// File: rtl/ensemble_vote_collector.sv
// Ensemble vote collector: captures one label from each of three classifier
// streams, forms a 2-of-3 majority vote and emits one AXI-Stream word per vote
// together with running vote / disagreement counters.
module ensemble_vote_collector #(
  parameter int DATA_WIDTH  = 32,
  parameter int KEEP_WIDTH  = 4,
  parameter int CLASS_WIDTH = 8,
  parameter int TIE_SEL     = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  ensemble_vote_collector_if.slave  s_axis_0,
  ensemble_vote_collector_if.slave  s_axis_1,
  ensemble_vote_collector_if.slave  s_axis_2,
  ensemble_vote_collector_if.master m_axis,
  output logic [31:0]             vote_count_o,
  output logic [31:0]             disagree_count_o,
  output logic                    tlast_mismatch_o
);

  localparam logic [0:0] ST_COLLECT = 1'b0;
  localparam logic [0:0] ST_EMIT    = 1'b1;

  logic [0:0]             state_q;
  logic [2:0]             held_q;
  logic [2:0]             tlast_q;
  logic [CLASS_WIDTH-1:0] label_q [3];
  logic                   m_tvalid_q;
  logic [DATA_WIDTH-1:0]  m_tdata_q;
  logic                   m_tlast_q;
  logic [31:0]            vote_count_q;
  logic [31:0]            disagree_count_q;
  logic                   mismatch_q;

  logic [2:0]             in_valid_s;
  logic [2:0]             in_tlast_s;
  logic [2:0]             ready_s;
  logic [CLASS_WIDTH-1:0] in_label_s [3];
  logic [CLASS_WIDTH-1:0] vote_s;
  logic [1:0]             agree_s;
  logic [DATA_WIDTH-1:0]  vote_word_d;
  logic                   unused_ok_s;

  assign in_valid_s    = {s_axis_2.tvalid, s_axis_1.tvalid, s_axis_0.tvalid};
  assign in_tlast_s    = {s_axis_2.tlast, s_axis_1.tlast, s_axis_0.tlast};
  assign in_label_s[0] = s_axis_0.tdata[CLASS_WIDTH-1:0];
  assign in_label_s[1] = s_axis_1.tdata[CLASS_WIDTH-1:0];
  assign in_label_s[2] = s_axis_2.tdata[CLASS_WIDTH-1:0];

  // Upper tdata bits and tkeep carry no information for the vote.
  assign unused_ok_s = ^{s_axis_0.tkeep, s_axis_1.tkeep, s_axis_2.tkeep,
                         s_axis_0.tdata[DATA_WIDTH-1:CLASS_WIDTH],
                         s_axis_1.tdata[DATA_WIDTH-1:CLASS_WIDTH],
                         s_axis_2.tdata[DATA_WIDTH-1:CLASS_WIDTH]};

  // A stream is ready only while collecting and not yet holding its label.
  assign ready_s         = (state_q == ST_COLLECT) ? ~held_q : 3'b000;
  assign s_axis_0.tready = ready_s[0];
  assign s_axis_1.tready = ready_s[1];
  assign s_axis_2.tready = ready_s[2];

  assign m_axis.tdata     = m_tdata_q;
  assign m_axis.tkeep     = {KEEP_WIDTH{1'b1}};
  assign m_axis.tvalid    = m_tvalid_q;
  assign m_axis.tlast     = m_tlast_q;
  assign vote_count_o     = vote_count_q;
  assign disagree_count_o = disagree_count_q;
  assign tlast_mismatch_o = mismatch_q;

  // Majority vote over the captured labels; TIE_SEL breaks a three-way split.
  always_comb begin
    vote_s  = label_q[0];
    agree_s = 2'd1;
    if ((label_q[0] == label_q[1]) && (label_q[1] == label_q[2])) begin
      vote_s  = label_q[0];
      agree_s = 2'd3;
    end else if ((label_q[0] == label_q[1]) || (label_q[0] == label_q[2])) begin
      vote_s  = label_q[0];
      agree_s = 2'd2;
    end else if (label_q[1] == label_q[2]) begin
      vote_s  = label_q[1];
      agree_s = 2'd2;
    end else begin
      agree_s = 2'd1;
      case (TIE_SEL)
        1:       vote_s = label_q[1];
        2:       vote_s = label_q[2];
        default: vote_s = label_q[0];
      endcase
    end
    vote_word_d = {{(DATA_WIDTH-CLASS_WIDTH-2){1'b0}}, agree_s, vote_s};
  end

  // Collect/emit state machine with capture registers, output word and statistics.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q          <= ST_COLLECT;
      held_q           <= 3'b000;
      tlast_q          <= 3'b000;
      for (int i = 0; i < 3; i++) label_q[i] <= '0;
      m_tvalid_q       <= 1'b0;
      m_tdata_q        <= '0;
      m_tlast_q        <= 1'b0;
      vote_count_q     <= 32'd0;
      disagree_count_q <= 32'd0;
      mismatch_q       <= 1'b0;
    end else begin
      case (state_q)
        ST_COLLECT: begin
          if (&held_q) begin
            state_q    <= ST_EMIT;
            m_tvalid_q <= 1'b1;
            m_tdata_q  <= vote_word_d;
            m_tlast_q  <= tlast_q[0];
            if (!((&tlast_q) || !(|tlast_q))) begin
              mismatch_q <= 1'b1;
            end
          end else begin
            for (int i = 0; i < 3; i++) begin
              if (in_valid_s[i] && ready_s[i]) begin
                label_q[i] <= in_label_s[i];
                tlast_q[i] <= in_tlast_s[i];
                held_q[i]  <= 1'b1;
              end
            end
          end
        end
        ST_EMIT: begin
          if (m_axis.tready) begin
            state_q      <= ST_COLLECT;
            held_q       <= 3'b000;
            m_tvalid_q   <= 1'b0;
            vote_count_q <= vote_count_q + 32'd1;
            if (m_tdata_q[CLASS_WIDTH+1 -: 2] != 2'd3) begin
              disagree_count_q <= disagree_count_q + 32'd1;
            end
          end
        end
        default: begin
          state_q    <= ST_COLLECT;
          held_q     <= 3'b000;
          m_tvalid_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ensemble_vote_collector.sv
// Self-checking bench for ensemble_vote_collector. Two instances (tie winner
// stream 2 and stream 0) receive identical stimulus and run in lockstep.
module tb_ensemble_vote_collector;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ensemble_vote_collector_if ia0 (), ia1 (), ia2 (), ma ();
  ensemble_vote_collector_if ib0 (), ib1 (), ib2 (), mb ();
  logic [31:0] vc_a, dc_a, vc_b, dc_b;
  logic        mm_a, mm_b;

  ensemble_vote_collector #(.TIE_SEL(2)) dut_a (
    .clk(clk), .rst(rst), .s_axis_0(ia0), .s_axis_1(ia1), .s_axis_2(ia2), .m_axis(ma),
    .vote_count_o(vc_a), .disagree_count_o(dc_a), .tlast_mismatch_o(mm_a));

  ensemble_vote_collector #(.TIE_SEL(0)) dut_b (
    .clk(clk), .rst(rst), .s_axis_0(ib0), .s_axis_1(ib1), .s_axis_2(ib2), .m_axis(mb),
    .vote_count_o(vc_b), .disagree_count_o(dc_b), .tlast_mismatch_o(mm_b));

  int n_checks = 0;
  int n_errors = 0;
  int exp_votes = 0;
  int exp_dis = 0;
  bit exp_mism = 1'b0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive stream i of both instances; upper data bits are random noise.
  task automatic drive(input int i, input bit v, input logic [7:0] lab, input bit tl);
    logic [31:0] d;
    d = $urandom;
    d[7:0] = lab;
    case (i)
      0: begin ia0.tdata = d; ia0.tvalid = v; ia0.tlast = tl; ia0.tkeep = 4'hf;
               ib0.tdata = d; ib0.tvalid = v; ib0.tlast = tl; ib0.tkeep = 4'hf; end
      1: begin ia1.tdata = d; ia1.tvalid = v; ia1.tlast = tl; ia1.tkeep = 4'hf;
               ib1.tdata = d; ib1.tvalid = v; ib1.tlast = tl; ib1.tkeep = 4'hf; end
      default: begin ia2.tdata = d; ia2.tvalid = v; ia2.tlast = tl; ia2.tkeep = 4'hf;
               ib2.tdata = d; ib2.tvalid = v; ib2.tlast = tl; ib2.tkeep = 4'hf; end
    endcase
  endtask

  task automatic idle_inputs();
    for (int i = 0; i < 3; i++) drive(i, 1'b0, 8'($urandom), 1'($urandom_range(0, 1)));
  endtask

  task automatic set_mready(input bit r);
    ma.tready = r;
    mb.tready = r;
  endtask

  function automatic logic [2:0] ready_a();
    return {ia2.tready, ia1.tready, ia0.tready};
  endfunction

  function automatic logic [2:0] ready_b();
    return {ib2.tready, ib1.tready, ib0.tready};
  endfunction

  // Reference vote: most frequent label wins; a three-way split goes to 'tie'.
  function automatic logic [31:0] model_vote(input logic [7:0] l0, l1, l2, input int tie);
    logic [7:0] l [3];
    int cnt [3];
    int best;
    l[0] = l0; l[1] = l1; l[2] = l2;
    best = 0;
    for (int i = 0; i < 3; i++) begin
      cnt[i] = 0;
      for (int j = 0; j < 3; j++) if (l[j] == l[i]) cnt[i]++;
    end
    for (int i = 0; i < 3; i++) if (cnt[i] > cnt[best]) best = i;
    if (cnt[best] == 1) best = tie;
    return {22'd0, 2'(cnt[best]), l[best]};
  endfunction

  // One complete vote: staggered captures, optional output back-pressure, handshake.
  task automatic do_vote(input string nm, input logic [7:0] l0, l1, l2,
                         input bit t0, t1, t2, input int d0, d1, d2, input int w);
    logic [7:0]  lab [3];
    bit          tl [3];
    int          d [3];
    int          m;
    logic [31:0] ea, eb;
    logic [2:0]  ra;
    bit          er;
    lab[0] = l0; lab[1] = l1; lab[2] = l2;
    tl[0] = t0; tl[1] = t1; tl[2] = t2;
    d[0] = d0; d[1] = d1; d[2] = d2;
    m = d0;
    if (d1 > m) m = d1;
    if (d2 > m) m = d2;
    ea = model_vote(l0, l1, l2, 2);
    eb = model_vote(l0, l1, l2, 0);
    set_mready(w == 0);
    for (int c = 0; c <= m + 1; c++) begin
      for (int i = 0; i < 3; i++) begin
        if (c == d[i]) drive(i, 1'b1, lab[i], tl[i]);
        else drive(i, 1'b0, 8'($urandom), 1'($urandom_range(0, 1)));
      end
      ra = ready_a();
      for (int i = 0; i < 3; i++) begin
        er = (c <= d[i]);
        n_checks++;
        if (ra[i] !== er) begin
          n_errors++;
          $display("FAIL %s tready_%0d cycle %0d: got %b expected %b", nm, i, c, ra[i], er);
        end
      end
      n_checks++;
      if (ma.tvalid !== 1'b0 || mb.tvalid !== 1'b0) begin
        n_errors++;
        $display("FAIL %s early tvalid cycle %0d: got %b/%b expected 0", nm, c, ma.tvalid, mb.tvalid);
      end
      tick();
    end
    idle_inputs();
    if (!(t0 == t1 && t1 == t2)) exp_mism = 1'b1;
    n_checks++;
    if (ma.tvalid !== 1'b1 || ma.tdata !== ea || ma.tlast !== t0 || ma.tkeep !== 4'hf) begin
      n_errors++;
      $display("FAIL %s out_a: got v=%b d=%h l=%b k=%h expected v=1 d=%h l=%b k=f",
               nm, ma.tvalid, ma.tdata, ma.tlast, ma.tkeep, ea, t0);
    end
    n_checks++;
    if (mb.tvalid !== 1'b1 || mb.tdata !== eb) begin
      n_errors++;
      $display("FAIL %s out_b: got v=%b d=%h expected v=1 d=%h", nm, mb.tvalid, mb.tdata, eb);
    end
    n_checks++;
    if (mm_a !== exp_mism || mm_b !== exp_mism) begin
      n_errors++;
      $display("FAIL %s tlast_mismatch: got %b/%b expected %b", nm, mm_a, mm_b, exp_mism);
    end
    for (int k = 0; k < w; k++) begin
      tick();
      n_checks++;
      if (ma.tvalid !== 1'b1 || ma.tdata !== ea || ready_a() !== 3'b000 || ready_b() !== 3'b000 ||
          vc_a !== 32'(exp_votes) || dc_a !== 32'(exp_dis)) begin
        n_errors++;
        $display("FAIL %s hold cycle %0d: got v=%b d=%h r=%b vc=%0d dc=%0d expected v=1 d=%h r=000 vc=%0d dc=%0d",
                 nm, k, ma.tvalid, ma.tdata, ready_a(), vc_a, dc_a, ea, exp_votes, exp_dis);
      end
    end
    set_mready(1'b1);
    tick();
    exp_votes++;
    if (ea[9:8] != 2'd3) exp_dis++;
    n_checks++;
    if (ma.tvalid !== 1'b0 || mb.tvalid !== 1'b0 || ready_a() !== 3'b111) begin
      n_errors++;
      $display("FAIL %s after handshake: got v=%b/%b r=%b expected v=0 r=111", nm, ma.tvalid, mb.tvalid, ready_a());
    end
    n_checks++;
    if (vc_a !== 32'(exp_votes) || dc_a !== 32'(exp_dis) || vc_b !== 32'(exp_votes) || dc_b !== 32'(exp_dis)) begin
      n_errors++;
      $display("FAIL %s counters: got vc=%0d/%0d dc=%0d/%0d expected vc=%0d dc=%0d",
               nm, vc_a, vc_b, dc_a, dc_b, exp_votes, exp_dis);
    end
    set_mready(1'b0);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_inputs();
    set_mready(1'b0);
    tick();
    tick();
    exp_votes = 0; exp_dis = 0; exp_mism = 1'b0;
    n_checks++;
    if (ma.tvalid !== 1'b0 || ma.tdata !== 32'd0 || ma.tlast !== 1'b0 || vc_a !== 32'd0 ||
        dc_a !== 32'd0 || mm_a !== 1'b0 || mb.tvalid !== 1'b0 || vc_b !== 32'd0) begin
      n_errors++;
      $display("FAIL reset state: got v=%b d=%h l=%b vc=%0d dc=%0d mm=%b expected all zero",
               ma.tvalid, ma.tdata, ma.tlast, vc_a, dc_a, mm_a);
    end
    rst = 1'b0;
    n_checks++;
    if (ready_a() !== 3'b111 || ready_b() !== 3'b111) begin
      n_errors++;
      $display("FAIL reset tready: got %b/%b expected 111", ready_a(), ready_b());
    end
  endtask

  task automatic test_unanimous();
    do_vote("unanimous", 8'd5, 8'd5, 8'd5, 1'b0, 1'b0, 1'b0, 0, 0, 0, 0);
  endtask

  task automatic test_staggered();
    do_vote("staggered", 8'd3, 8'd7, 8'd3, 1'b0, 1'b0, 1'b0, 0, 4, 2, 0);
  endtask

  task automatic test_tie();
    do_vote("tie", 8'd1, 8'd2, 8'd4, 1'b0, 1'b0, 1'b0, 1, 0, 2, 0);
  endtask

  task automatic test_backpressure();
    do_vote("backpressure", 8'd9, 8'd200, 8'd200, 1'b1, 1'b1, 1'b1, 2, 0, 1, 10);
    do_vote("after_bp", 8'd17, 8'd17, 8'd17, 1'b0, 1'b0, 1'b0, 0, 0, 0, 0);
  endtask

  task automatic test_tlast_mismatch();
    do_vote("tlast_mismatch", 8'd6, 8'd6, 8'd1, 1'b1, 1'b0, 1'b1, 0, 1, 0, 0);
    for (int k = 0; k < 3; k++)
      do_vote("clean_after_mismatch", 8'(k), 8'(k), 8'(k), 1'b0, 1'b0, 1'b0, k, 0, 1, 1);
  endtask

  task automatic test_reset_mid();
    drive(0, 1'b1, 8'd9, 1'b1);
    drive(1, 1'b1, 8'd9, 1'b1);
    drive(2, 1'b0, 8'd9, 1'b1);
    tick();
    idle_inputs();
    n_checks++;
    if (ready_a() !== 3'b100) begin
      n_errors++;
      $display("FAIL partial capture tready: got %b expected 100", ready_a());
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_votes = 0; exp_dis = 0; exp_mism = 1'b0;
    for (int k = 0; k < 3; k++) begin
      n_checks++;
      if (ready_a() !== 3'b111 || ma.tvalid !== 1'b0 || vc_a !== 32'd0 || dc_a !== 32'd0 || mm_a !== 1'b0) begin
        n_errors++;
        $display("FAIL reset_mid cycle %0d: got r=%b v=%b vc=%0d dc=%0d mm=%b expected r=111 v=0 vc=0 dc=0 mm=0",
                 k, ready_a(), ma.tvalid, vc_a, dc_a, mm_a);
      end
      tick();
    end
    do_vote("fresh_after_reset", 8'd4, 8'd6, 8'd6, 1'b0, 1'b0, 1'b0, 3, 0, 1, 0);
  endtask

  task automatic test_random();
    for (int n = 0; n < 40; n++) begin
      bit tl0;
      tl0 = 1'($urandom_range(0, 1));
      do_vote("random",
              8'($urandom_range(0, 3)), 8'($urandom_range(0, 3)), 8'($urandom_range(0, 3)),
              tl0, ($urandom_range(0, 7) == 0) ? ~tl0 : tl0, tl0,
              $urandom_range(0, 4), $urandom_range(0, 4), $urandom_range(0, 4),
              $urandom_range(0, 3));
    end
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    set_mready(1'b0);
    test_reset();
    test_unanimous();
    test_staggered();
    test_tie();
    test_backpressure();
    test_tlast_mismatch();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
